// File: rtl/spi_pkg.sv
// Shared definitions for the SPI shift engine: FSM state encoding, strobe
// decode for the four CPOL/CPHA modes, and the frame length clamp.
package spi_pkg;

  typedef logic [0:0] spi_state_t;

  localparam spi_state_t IDLE   = 1'b0;
  localparam spi_state_t ACTIVE = 1'b1;

  // Returns {sample, shift}. Both strobes high together counts as a sample only.
  function automatic logic [1:0] decode_strobes(input logic cpol,
                                                input logic cpha,
                                                input logic sclk_rise,
                                                input logic sclk_fall);
    logic samp;
    logic shft;
    if (cpol ^ cpha) begin
      samp = sclk_fall;
      shft = sclk_rise & ~sclk_fall;
    end else begin
      samp = sclk_rise;
      shft = sclk_fall & ~sclk_rise;
    end
    return {samp, shft};
  endfunction

  function automatic int unsigned clamp_len(input int unsigned flen,
                                            input int unsigned max_len);
    return (flen == 0 || flen > max_len) ? max_len : flen;
  endfunction

endpackage

// File: rtl/spi_bit_counter.sv
// Frame bit counter: counts samples up to the frame length and turns the
// count into a one-hot mask selecting the current bit for either bit order.
module spi_bit_counter #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_W      = $clog2(DATA_WIDTH + 1)
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  clr,
  input  logic                  inc,
  input  logic [CNT_W-1:0]      limit,
  input  logic                  lsbfe,
  output logic [CNT_W-1:0]      count,
  output logic                  last,
  output logic [DATA_WIDTH-1:0] bit_mask
);

  logic [CNT_W-1:0] pos;

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count < limit)) begin
      count <= count + CNT_W'(1);
    end
  end

  assign last = (count == limit - CNT_W'(1));

  // MSB-first walks down from limit-1, LSB-first walks up from 0.
  assign pos      = lsbfe ? count : (limit - CNT_W'(1) - count);
  assign bit_mask = {{(DATA_WIDTH-1){1'b0}}, 1'b1} << pos;

endmodule

// File: rtl/spi_shift_engine.sv
// Full-duplex SPI shift engine: frame FSM, tx/rx shift datapath and output
// registers, driven by one-cycle SCLK edge strobes from the baud generator.
module spi_shift_engine
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_W      = $clog2(DATA_WIDTH + 1)
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  ss_n,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic [CNT_W-1:0]      frame_len,
  input  logic                  cpol,
  input  logic                  cpha,
  input  logic                  lsbfe,
  input  logic                  sclk_rise,
  input  logic                  sclk_fall,
  input  logic                  miso,
  output logic                  mosi,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  busy,
  output logic                  abort,
  output spi_state_t            state_dbg
);

  // Handshake: load is a request taken only while busy=0 (IDLE); rx_valid and
  // abort are single-cycle pulses with no back-pressure, rx_data is held until
  // the next completed frame.

  spi_state_t            state;
  logic                  cpol_q, cpha_q, lsbfe_q;
  logic [CNT_W-1:0]      len_q;
  logic [DATA_WIDTH-1:0] tx_q;
  logic [DATA_WIDTH-1:0] rx_sr;

  logic                  sample_stb, shift_stb;
  logic                  do_abort, do_sample, do_shift, do_final, accept;
  logic [CNT_W-1:0]      count;
  logic                  last;
  logic [DATA_WIDTH-1:0] bit_mask;
  logic [DATA_WIDTH-1:0] rx_next;
  logic                  tx_bit;

  logic [CNT_W-1:0]      len_in;
  logic [CNT_W-1:0]      first_pos;
  logic [DATA_WIDTH-1:0] first_mask;
  logic                  first_bit;

  assign {sample_stb, shift_stb} = decode_strobes(cpol_q, cpha_q, sclk_rise, sclk_fall);

  assign accept    = (state == IDLE) && load;
  assign do_abort  = (state == ACTIVE) && ss_n;
  assign do_sample = (state == ACTIVE) && !ss_n && sample_stb;
  // With cpha=0 the first bit went out at load, so the leading shift edge is skipped.
  assign do_shift  = (state == ACTIVE) && !ss_n && shift_stb && (cpha_q || (count != '0));
  assign do_final  = do_sample && last;

  spi_bit_counter #(
    .DATA_WIDTH (DATA_WIDTH),
    .CNT_W      (CNT_W)
  ) u_cnt (
    .PCLK     (PCLK),
    .PRESET   (PRESET),
    .clr      (accept || do_abort || do_final),
    .inc      (do_sample),
    .limit    (len_q),
    .lsbfe    (lsbfe_q),
    .count    (count),
    .last     (last),
    .bit_mask (bit_mask)
  );

  assign rx_next = miso ? (rx_sr | bit_mask) : (rx_sr & ~bit_mask);
  assign tx_bit  = |(tx_q & bit_mask);

  // First bit is selected from the raw inputs because the config is latched in the same cycle.
  assign len_in     = CNT_W'(clamp_len(32'(frame_len), 32'(DATA_WIDTH)));
  assign first_pos  = lsbfe ? '0 : (len_in - CNT_W'(1));
  assign first_mask = {{(DATA_WIDTH-1){1'b0}}, 1'b1} << first_pos;
  assign first_bit  = |(tx_data & first_mask);

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state    <= IDLE;
      cpol_q   <= 1'b0;
      cpha_q   <= 1'b0;
      lsbfe_q  <= 1'b0;
      len_q    <= '0;
      tx_q     <= '0;
      rx_sr    <= '0;
      mosi     <= 1'b0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      abort    <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      abort    <= 1'b0;
      case (state)
        IDLE: begin
          if (load) begin
            cpol_q  <= cpol;
            cpha_q  <= cpha;
            lsbfe_q <= lsbfe;
            len_q   <= len_in;
            tx_q    <= tx_data;
            rx_sr   <= '0;
            state   <= ACTIVE;
            if (!cpha) begin
              mosi <= first_bit;
            end
          end
        end
        ACTIVE: begin
          if (do_abort) begin
            abort <= 1'b1;
            state <= IDLE;
          end else begin
            if (do_sample) begin
              rx_sr <= rx_next;
            end
            if (do_final) begin
              rx_data  <= rx_next;
              rx_valid <= 1'b1;
              state    <= IDLE;
            end
            if (do_shift) begin
              mosi <= tx_bit;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy      = (state == ACTIVE);
  assign state_dbg = state;

endmodule

// File: tb/tb_spi_shift_engine.sv
// Directed bench for spi_shift_engine: drivers issue frames and strobes, a
// scoreboard queue holds expected rx_data and a monitor checks each pulse.
module tb_spi_shift_engine;
  import spi_pkg::*;

  localparam int DW = 8;
  localparam int CW = $clog2(DW + 1);

  logic          PCLK;
  logic          PRESET;
  logic          ss_n;
  logic          load;
  logic [DW-1:0] tx_data;
  logic [CW-1:0] frame_len;
  logic          cpol, cpha, lsbfe;
  logic          sclk_rise, sclk_fall;
  logic          miso;
  logic          mosi;
  logic [DW-1:0] rx_data;
  logic          rx_valid;
  logic          busy;
  logic          abort;
  spi_state_t    state_dbg;

  logic          loop_en;
  logic          miso_v;

  int            n_checks = 0;
  int            n_fail   = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] abort_q[$];
  logic [DW-1:0] last_rx;

  assign miso = loop_en ? mosi : miso_v;

  spi_shift_engine #(.DATA_WIDTH(DW)) dut (
    .PCLK      (PCLK),
    .PRESET    (PRESET),
    .ss_n      (ss_n),
    .load      (load),
    .tx_data   (tx_data),
    .frame_len (frame_len),
    .cpol      (cpol),
    .cpha      (cpha),
    .lsbfe     (lsbfe),
    .sclk_rise (sclk_rise),
    .sclk_fall (sclk_fall),
    .miso      (miso),
    .mosi      (mosi),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .busy      (busy),
    .abort     (abort),
    .state_dbg (state_dbg)
  );

  // ---------------- clock ----------------
  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge PCLK) begin
    if (!PRESET && rx_valid) begin
      if (exp_q.size() == 0) chk("unexpected_rx_valid", 32'(rx_valid), 32'(0));
      else begin
        chk("rx_data", 32'(rx_data), 32'(exp_q.pop_front()));
        chk("busy_at_rx_valid", 32'(busy), 32'(0));
      end
    end
    if (!PRESET && abort) begin
      if (abort_q.size() == 0) chk("unexpected_abort", 32'(abort), 32'(0));
      else begin
        chk("rx_data_kept_on_abort", 32'(rx_data), 32'(abort_q.pop_front()));
        chk("busy_at_abort", 32'(busy), 32'(0));
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((exp_q.size() != 0 || abort_q.size() != 0) && k < 10) begin
      tick();
      k++;
    end
    chk("pending_responses", 32'(exp_q.size() + abort_q.size()), 32'(0));
  endtask

  task automatic strobe(input bit is_rise, input bit check, input bit exp_b);
    sclk_rise = is_rise;
    sclk_fall = !is_rise;
    @(negedge PCLK);
    if (check) chk("mosi_at_sample", 32'(mosi), 32'(exp_b));
    tick();
    sclk_rise = 1'b0;
    sclk_fall = 1'b0;
  endtask

  task automatic do_load(input bit cp, input bit ch, input bit lf, input logic [CW-1:0] fl,
                         input logic [DW-1:0] tx, input bit hold_chk, input bit hold_exp);
    cpol = cp; cpha = ch; lsbfe = lf; frame_len = fl; tx_data = tx;
    load = 1'b1;
    tick();
    load = 1'b0;
    // Configuration changes while ACTIVE must not disturb the frame.
    cpol = ~cp; cpha = ~ch; lsbfe = ~lf;
    frame_len = CW'($urandom_range(0, 15));
    tx_data   = DW'($urandom_range(0, 255));
    @(negedge PCLK);
    chk("busy_after_load", 32'(busy), 32'(1));
    if (hold_chk) chk("mosi_hold_after_load", 32'(mosi), 32'(hold_exp));
    tick();
  endtask

  task automatic frame(input bit cp, input bit ch, input bit lf, input logic [CW-1:0] fl,
                       input logic [DW-1:0] tx, input bit loop, input bit mv, input int nbits,
                       input bit complete, input bit wait_done, input bit poke_load,
                       input bit hold_chk, input bit hold_exp);
    int            len;
    logic [DW-1:0] mask;
    logic [DW-1:0] exp_rx;
    bit            lead_rise;
    len       = (fl == 0 || int'(fl) > DW) ? DW : int'(fl);
    mask      = (len == DW) ? '1 : DW'((1 << len) - 1);
    exp_rx    = loop ? (tx & mask) : (mv ? mask : '0);
    loop_en   = loop;
    miso_v    = mv;
    lead_rise = (cp == 1'b0);
    do_load(cp, ch, lf, fl, tx, hold_chk, hold_exp);
    if (complete) begin
      exp_q.push_back(exp_rx);
      last_rx = exp_rx;
    end
    for (int i = 0; i < nbits; i++) begin
      int idx;
      bit eb;
      idx = lf ? i : (len - 1 - i);
      eb  = tx[idx];
      if (!ch) begin
        strobe(lead_rise, 1'b1, eb);
        if (poke_load && i == 2) begin
          load = 1'b1;
          tx_data = ~tx;
          tick();
          load = 1'b0;
        end else begin
          tick();
        end
        strobe(!lead_rise, 1'b0, 1'b0);
        tick();
      end else begin
        strobe(lead_rise, 1'b0, 1'b0);
        tick();
        strobe(!lead_rise, 1'b1, eb);
        if (i != nbits - 1) tick();
      end
    end
    if (wait_done) drain();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    PRESET = 1'b1; ss_n = 1'b0; load = 1'b0; tx_data = '0; frame_len = '0;
    cpol = 1'b0; cpha = 1'b0; lsbfe = 1'b0; sclk_rise = 1'b0; sclk_fall = 1'b0;
    loop_en = 1'b0; miso_v = 1'b0; last_rx = '0;

    @(negedge PCLK);
    chk("reset_mosi",     32'(mosi),     32'(0));
    chk("reset_rx_data",  32'(rx_data),  32'(0));
    chk("reset_rx_valid", 32'(rx_valid), 32'(0));
    chk("reset_busy",     32'(busy),     32'(0));
    chk("reset_abort",    32'(abort),    32'(0));
    tick();
    PRESET = 1'b0;
    tick();

    // Mode 0, MSB first, loopback
    frame(1'b0, 1'b0, 1'b0, CW'(8), 8'hA5, 1'b1, 1'b0, 8, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    // Mode 3, LSB first, miso held high
    frame(1'b1, 1'b1, 1'b1, CW'(8), 8'h3C, 1'b0, 1'b1, 8, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    // Mode 1, 5-bit frame; mosi keeps the previous frame's last bit (0) until first shift
    frame(1'b0, 1'b1, 1'b0, CW'(5), 8'h13, 1'b1, 1'b0, 5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    // Clamped lengths: 0 and 12 both run 8 bits
    frame(1'b1, 1'b0, 1'b0, CW'(0),  8'hC3, 1'b1, 1'b0, 8, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    frame(1'b0, 1'b0, 1'b1, CW'(12), 8'h96, 1'b1, 1'b0, 8, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    // Single-bit frame
    frame(1'b0, 1'b0, 1'b0, CW'(1), 8'hFE, 1'b0, 1'b1, 1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

    // Abort after three samples; rx_data must keep 0x01
    frame(1'b0, 1'b0, 1'b0, CW'(8), 8'h5A, 1'b1, 1'b0, 3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    abort_q.push_back(last_rx);
    ss_n = 1'b1;
    @(negedge PCLK);
    chk("busy_before_abort", 32'(busy), 32'(1));
    tick();
    ss_n = 1'b0;
    @(negedge PCLK);
    chk("busy_after_abort", 32'(busy), 32'(0));
    tick();
    drain();
    frame(1'b0, 1'b0, 1'b0, CW'(8), 8'h81, 1'b1, 1'b0, 8, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

    // Back-to-back frames, the second with an ignored load mid-frame
    frame(1'b0, 1'b1, 1'b0, CW'(8), 8'h4E, 1'b1, 1'b0, 8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    frame(1'b1, 1'b0, 1'b1, CW'(8), 8'hB1, 1'b1, 1'b0, 8, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);

    // Reset mid-frame forces every output low immediately
    frame(1'b0, 1'b0, 1'b0, CW'(8), 8'hFF, 1'b1, 1'b0, 4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #2;
    PRESET = 1'b1;
    #1;
    chk("midreset_mosi",     32'(mosi),     32'(0));
    chk("midreset_rx_data",  32'(rx_data),  32'(0));
    chk("midreset_rx_valid", 32'(rx_valid), 32'(0));
    chk("midreset_busy",     32'(busy),     32'(0));
    chk("midreset_abort",    32'(abort),    32'(0));
    tick();
    PRESET = 1'b0;
    tick();
    frame(1'b0, 1'b0, 1'b0, CW'(8), 8'h7E, 1'b1, 1'b0, 8, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_shift_engine.md
# spi_shift_engine

Parametrised full-duplex SPI shift engine for the SPI master datapath. It sits between the APB register file, which supplies transmit data and frame configuration, and the baud/SCLK generator, which supplies one-cycle edge strobes. It serialises `tx_data` onto `mosi` and deserialises `miso` into `rx_data` in all four CPOL/CPHA modes, either bit order, and with a runtime frame length of 1..DATA_WIDTH bits. It adds what the 8-bit fixed engine lacks: a real frame FSM, completion and abort signalling, and right-justified variable-length frames.

## Interface
- `DATA_WIDTH`, default 8: maximum frame length in bits (legal range 2..32).
- `CNT_W`, default `$clog2(DATA_WIDTH+1)`: width of the bit counter and `frame_len`; derived, do not override.
- `PCLK`  in  1  system clock; all logic on the rising edge.
- `PRESET`  in  1  reset, asynchronous and active-high.
- `ss_n`  in  1  slave select, active low; shifting only occurs while it is low.
- `load`  in  1  one-cycle request to start a frame; honoured only in IDLE.
- `tx_data`  in  DATA_WIDTH  transmit word, right-justified.
- `frame_len`  in  CNT_W  frame length in bits; sampled at load.
- `cpol`, `cpha`, `lsbfe`  in  1 each  mode and bit order (lsbfe=1 means LSB first); sampled at load.
- `sclk_rise`, `sclk_fall`  in  1 each  one-cycle strobes from the SCLK generator, asserted in the PCLK cycle before the SCLK edge.
- `miso`  in  1  serial input; must be synchronised upstream.
- `mosi`  out  1  serial output, registered.
- `rx_data`  out  DATA_WIDTH  received word, right-justified; bits at index frame_len and above are always 0.
- `rx_valid`  out  1  one-cycle pulse when `rx_data` is updated.
- `busy`  out  1  high in ACTIVE.
- `abort`  out  1  one-cycle pulse when a frame is aborted.

## Operation
- Reset values: `mosi`=0, `rx_data`=0, `rx_valid`=0, `busy`=0, `abort`=0; state IDLE; counter 0; shift registers 0.
- Latched configuration: `cpol`, `cpha`, `lsbfe`, `frame_len` and `tx_data` are captured when `load` is accepted. Input changes during ACTIVE have no effect.
- Frame length clamping: `frame_len` of 0 or greater than DATA_WIDTH is clamped to DATA_WIDTH. Call the result L.
- Strobe selection, with m = cpol XOR cpha:
  - m=0: sample strobe = `sclk_rise`, shift strobe = `sclk_fall`.
  - m=1: sample strobe = `sclk_fall`, shift strobe = `sclk_rise`.
- Bit order: the first bit sent or received is index 0 if lsbfe=1, otherwise index L-1. Subsequent bits walk toward the opposite end of the frame.
- FSM states:
  - IDLE: `load`=1 latches the configuration and moves to ACTIVE. If cpha=0, `mosi` is also driven with the first bit here.
  - ACTIVE, on each sample strobe while `ss_n`=0: capture `miso` into the current rx bit position and increment the counter.
  - ACTIVE, on each shift strobe while `ss_n`=0:
    - cpha=1: drive the next tx bit onto `mosi`.
    - cpha=0: drive the next tx bit only if at least one sample has occurred.
  - ACTIVE, on the sample that makes count equal L: copy the rx shift register to `rx_data`, pulse `rx_valid`, clear the counter, return to IDLE. `mosi` holds its last value.
  - ACTIVE with `ss_n`=1 at any cycle: return to IDLE, pulse `abort`, clear the counter, leave `rx_data` unchanged, no `rx_valid`.
- Boundary rules:
  - `load` in ACTIVE is ignored.
  - Both strobes high in the same cycle is a generator error; treat it as a sample strobe only.
  - Strobes in IDLE are ignored.
  - When abort and the final sample coincide, abort wins.
  - Counter saturation: the counter never exceeds L.

## Timing
- `load` accepted in cycle N: `busy`=1 and (for cpha=0) the first bit on `mosi` from cycle N+1.
- Final sample strobe in cycle N: `rx_valid`=1 and new `rx_data` in cycle N+1; `busy`=0 in cycle N+1.
- A new `load` is accepted in cycle N+1 (back-to-back frames, zero idle cycles).
- `ss_n` rising in cycle N: `abort`=1 and `busy`=0 in cycle N+1.
- Asserting `PRESET` mid-frame forces all reset values immediately; there is no recovery beyond reset.

## Structure
- Package `spi_pkg` holds:
  - `spi_state_t` (IDLE, ACTIVE);
  - the mode decode function giving the sample and shift strobe from cpol, cpha and the two strobes;
  - the `frame_len` clamp function.
- Sub-module `spi_bit_counter` provides:
  - a CNT_W counter with clear, increment and limit L;
  - outputs `count` and `last` (count == L-1 on a sample);
  - the next bit index for both bit orders.
- The top level holds the FSM, the tx/rx shift registers and the output registers.

## Test plan
- Mode 0, DATA_WIDTH=8, L=8, lsbfe=0, tx=0xA5, miso looped to mosi: `mosi` sequence 1,0,1,0,0,1,0,1; `rx_data`=0xA5; one `rx_valid` pulse.
- Mode 3, lsbfe=1, tx=0x3C, miso held 1: `mosi` sequence 0,0,1,1,1,1,0,0; `rx_data`=0xFF.
- Mode 1, L=5, lsbfe=0, tx=0x13, loopback: first `mosi` change occurs at the first shift strobe; `rx_data`=0x13 with bits 7:5 = 0.
- `frame_len`=0, then `frame_len`=12 with DATA_WIDTH=8: both frames run 8 bits.
- `ss_n` raised after 3 samples: `abort` pulse, `rx_data` keeps its prior value, `busy`=0 next cycle; next `load` completes normally.
- Back-to-back frames: `load` in the cycle after `rx_valid` is accepted. `load` during ACTIVE is ignored. `PRESET` mid-frame gives all outputs 0.
